boolean_sweep_ctrl: RTL
=======================

# boolean_sweep_ctrl

Sequencing controller for the team's 4-input combinational `boolean_function` block (inputs a, b, c, d; output y). On a start pulse it steps all 16 input combinations through the function and samples y after a programmable settle time. It assembles the 16-bit truth table and compares it against a golden mask, reporting pass/fail, the mismatch count and the first failing vector. It sits beside the combinational function as its on-chip self-check sequencer.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is driven before y is sampled; legal range 1..15.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a sweep; honoured only in IDLE.
- `expected`  in  16  golden truth table; bit i is the expected y for vector i; latched on an accepted start.
- `y`  in  1  output of the boolean function.
- `a`, `b`, `c`, `d`  out  1 each  function inputs; `{a,b,c,d}` = vector index, a = MSB.
- `busy`  out  1  high while a sweep is in progress (DRIVE/SAMPLE).
- `done`  out  1  one-cycle pulse when a sweep completes.
- `truth_table`  out  16  sampled y values; bit i = y for vector i.
- `pass`  out  1  1 when the last completed sweep had zero mismatches.
- `mismatch_count`  out  5  number of mismatching vectors, 0..16.
- `fail_valid`  out  1  at least one mismatch in the last sweep.
- `first_fail_idx`  out  4  lowest mismatching vector index; 0 when fail_valid = 0.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - a..d = 0 and busy = 0.
  - On start = 1: latch expected; clear truth_table, mismatch_count, fail_valid, first_fail_idx and pass; set idx = 0 and settle counter = 0; go to DRIVE.
- DRIVE:
  - `{a,b,c,d}` = idx.
  - The settle counter increments each cycle. After SETTLE_CYCLES cycles in DRIVE, go to SAMPLE.
- SAMPLE:
  - `{a,b,c,d}` is still held at idx; write truth_table[idx] = y.
  - If y ≠ expected_latched[idx]: increment mismatch_count. If fail_valid = 0, set first_fail_idx = idx and fail_valid = 1.
  - If idx = 15, go to DONE. Otherwise idx++, clear the settle counter and go to DRIVE.
- DONE:
  - done = 1 for exactly this cycle; busy = 0; a..d = 0.
  - pass = 1 if the mismatch count (including the final SAMPLE) is 0.
  - Go to IDLE.
- Result outputs hold their values until the next accepted start or reset.
- start while busy or in DONE is ignored; expected is not re-latched.
- Reset, at any time including mid-sweep: state = IDLE and all outputs = 0 (a..d, busy, done, truth_table, pass, mismatch_count, fail_valid, first_fail_idx); the sweep is aborted and no done pulse is issued.
- mismatch_count is 5 bits so that 16 is representable; no saturation logic is needed.

## Timing
- Each vector occupies SETTLE_CYCLES + 1 cycles: SETTLE_CYCLES in DRIVE, 1 in SAMPLE.
- If start is sampled high in cycle n:
  - DRIVE for vector 0 begins in cycle n+1.
  - The last SAMPLE occurs in cycle n + 16·(SETTLE_CYCLES+1).
  - done is high in cycle n + 16·(SETTLE_CYCLES+1) + 1.
- With the default SETTLE_CYCLES = 2, done is high in cycle n+49.
- busy is high from cycle n+1 through the last SAMPLE inclusive.
- pass, mismatch_count and first_fail_idx are final when done is high.
- y is sampled combinationally at the SAMPLE-cycle clock edge; the function must settle within SETTLE_CYCLES cycles.
- A new start is accepted in the cycle after DONE at the earliest.

## Structure
- Package `boolean_sweep_pkg` contains:
  - the state enum (IDLE, DRIVE, SAMPLE, DONE)
  - `N_VARS = 4`, `N_VECTORS = 16`
  - the vector-index typedef (4 bits) and the count typedef (5 bits).
- One sub-module, `sweep_settle_counter`: a loadable/clearable counter that raises an expiry flag after SETTLE_CYCLES cycles.
- The boolean function itself is instantiated outside this block and connected through a..d and y.

## Test plan
- Bench models y = a & b; expected = 16'hF000; start in cycle n → truth_table = 16'hF000, pass = 1, mismatch_count = 0, fail_valid = 0, done high in cycle n+49 only.
- Same model with expected = 16'hF001 → mismatch_count = 1, fail_valid = 1, first_fail_idx = 0, pass = 0.
- y tied to 1 with expected = 16'h0000 → truth_table = 16'hFFFF, mismatch_count = 16, first_fail_idx = 0, pass = 0.
- Assert rst while a..d = 4'b0111 (mid-sweep) → all outputs are 0 within the same cycle and no done pulse; a following start gives a full, correct sweep.
- Pulse start again 10 cycles into a sweep with a different expected value → ignored; exactly one done pulse, with results computed from the originally latched mask.
- SETTLE_CYCLES = 1 → a..d step 0000, 0001, … 1111, each value held 2 cycles; done high in cycle n+33.

Source files
------------

// File: rtl/boolean_sweep_ctrl_pkg.sv
// Shared types and constants for the boolean function sweep controller.
// Holds the FSM state enum and the vector/count widths.
package boolean_sweep_pkg;

  localparam int N_VARS    = 4;
  localparam int N_VECTORS = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef logic [N_VARS-1:0] vec_idx_t;
  typedef logic [4:0]        vec_cnt_t;

endpackage

// File: rtl/boolean_sweep_ctrl_if.sv
// Signal bundle between the sweep controller and its user / function under test.
// slave = controller side, master = stimulus / function side.
interface boolean_sweep_ctrl_if;
  import boolean_sweep_pkg::*;

  logic                 start;
  logic [N_VECTORS-1:0] expected;
  logic                 y;
  logic                 a;
  logic                 b;
  logic                 c;
  logic                 d;
  logic                 busy;
  logic                 done;
  logic [N_VECTORS-1:0] truth_table;
  logic                 pass;
  vec_cnt_t             mismatch_count;
  logic                 fail_valid;
  vec_idx_t             first_fail_idx;

  modport slave (
    input  start, expected, y,
    output a, b, c, d, busy, done, truth_table, pass,
           mismatch_count, fail_valid, first_fail_idx
  );

  modport master (
    output start, expected, y,
    input  a, b, c, d, busy, done, truth_table, pass,
           mismatch_count, fail_valid, first_fail_idx
  );
endinterface

// File: rtl/boolean_sweep_ctrl_settle_counter.sv
// Settle-time counter: counts cycles while enabled and flags the last
// settle cycle so the FSM can move to SAMPLE on the following edge.
module sweep_settle_counter #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // High during the SETTLE_CYCLES-th enabled cycle.
  assign o_expired = i_en && (r_cnt == 4'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/boolean_sweep_ctrl.sv
// Self-check sequencer: walks all 16 input vectors of a 4-input function,
// samples y after a settle time and scores the truth table against a mask.
module boolean_sweep_ctrl
  import boolean_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  boolean_sweep_ctrl_if.slave bus
);

  state_t               r_state;
  state_t               w_next;
  vec_idx_t             r_idx;
  logic [N_VECTORS-1:0] r_exp;
  logic [N_VECTORS-1:0] r_tt;
  vec_cnt_t             r_mcount;
  logic                 r_fail;
  vec_idx_t             r_ffi;
  logic                 r_pass;

  logic                 w_busy;
  logic                 w_done;
  vec_idx_t             w_vec;
  logic                 w_expired;
  logic                 w_mis;
  vec_cnt_t             w_mcount_nxt;
  logic                 w_last;

  sweep_settle_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (r_state != DRIVE),
    .i_en     (r_state == DRIVE),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  assign w_last = (r_idx == vec_idx_t'(N_VECTORS - 1));

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    w_vec  = '0;
    case (r_state)
      IDLE: begin
        if (bus.start) w_next = DRIVE;
      end
      DRIVE: begin
        w_busy = 1'b1;
        w_vec  = r_idx;
        if (w_expired) w_next = SAMPLE;
      end
      SAMPLE: begin
        w_busy = 1'b1;
        w_vec  = r_idx;
        w_next = w_last ? DONE : DRIVE;
      end
      DONE: begin
        w_done = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_mis        = bus.y ^ r_exp[r_idx];
  assign w_mcount_nxt = r_mcount + {4'd0, w_mis};

  // Results are cleared on an accepted start and otherwise only move in SAMPLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx    <= '0;
      r_exp    <= '0;
      r_tt     <= '0;
      r_mcount <= '0;
      r_fail   <= 1'b0;
      r_ffi    <= '0;
      r_pass   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_exp    <= bus.expected;
            r_tt     <= '0;
            r_mcount <= '0;
            r_fail   <= 1'b0;
            r_ffi    <= '0;
            r_pass   <= 1'b0;
            r_idx    <= '0;
          end
        end
        SAMPLE: begin
          r_tt[r_idx] <= bus.y;
          r_mcount    <= w_mcount_nxt;
          if (w_mis && !r_fail) begin
            r_fail <= 1'b1;
            r_ffi  <= r_idx;
          end
          if (w_last) begin
            r_pass <= (w_mcount_nxt == '0);
          end else begin
            r_idx <= r_idx + vec_idx_t'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.a              = w_vec[3];
  assign bus.b              = w_vec[2];
  assign bus.c              = w_vec[1];
  assign bus.d              = w_vec[0];
  assign bus.busy           = w_busy;
  assign bus.done           = w_done;
  assign bus.truth_table    = r_tt;
  assign bus.pass           = r_pass;
  assign bus.mismatch_count = r_mcount;
  assign bus.fail_valid     = r_fail;
  assign bus.first_fail_idx = r_ffi;

endmodule
